// File: rtl/l1_pkg.sv
// Shared types for the L1 cache: controller state encoding and the processor word width.
// Pure declarations; no timing or flow-control behaviour of its own.
package l1_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

endpackage

// File: rtl/l1_cache_nway_if.sv
// Bundles the processor-side and L2-side signals of the L1 cache; master is the environment, slave the cache.
// Wires only: no latency; proc_stall and L2 ready/stall carry the flow control.
interface l1_cache_nway_if
  import l1_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int LINE_WORDS = 4
);
  localparam int LADDR_W = ADDR_W - $clog2(LINE_WORDS);

  logic                         proc_read;
  logic                         proc_write;
  logic [ADDR_W-1:0]            proc_addr;
  logic [WORD_W-1:0]            proc_wdata;
  logic                         proc_stall;
  logic [WORD_W-1:0]            proc_rdata;
  logic                         read;
  logic                         write;
  logic [LADDR_W-1:0]           addr;
  logic [WORD_W*LINE_WORDS-1:0] wdata;
  logic [WORD_W*LINE_WORDS-1:0] rdata;
  logic                         ready;
  logic                         stall;
  logic [15:0]                  acc_cnt;
  logic [15:0]                  miss_cnt;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, rdata, ready, stall,
    input  proc_stall, proc_rdata, read, write, addr, wdata, acc_cnt, miss_cnt
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, rdata, ready, stall,
    output proc_stall, proc_rdata, read, write, addr, wdata, acc_cnt, miss_cnt
  );

endinterface

// File: rtl/l1_lru.sv
// Age vector for one set: the hit way becomes age 0, younger ways age by one; victim is the way aged WAYS-1.
// Update lands on the next edge; the caller freezes ages simply by holding hit_en low.
module l1_lru #(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_en,
  input  logic [AGE_W-1:0] hit_way,
  output logic [AGE_W-1:0] victim
);

  logic [AGE_W-1:0] age_q [WAYS];
  logic [AGE_W-1:0] age_d [WAYS];

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      age_d[w] = age_q[w];
      if (hit_en) begin
        if (AGE_W'(w) == hit_way) begin
          age_d[w] = '0;
        end else if (age_q[w] < age_q[hit_way]) begin
          age_d[w] = AGE_W'(age_q[w] + 1'b1);
        end
      end
      if (age_q[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) age_q[w] <= AGE_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/l1_cache_nway.sv
// N-way set-associative write-back L1 with LRU replacement; define L1_PERF_CNT_EN for access/miss counters.
// Hit completes 2 edges after the request edge; misses wait on L2 ready, and stall=1 freezes every register.
module l1_cache_nway
  import l1_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int WAYS       = 2,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                                  clk,
  input  logic                                  proc_reset_n,
  input  logic                                  proc_read,
  input  logic                                  proc_write,
  input  logic [ADDR_W-1:0]                     proc_addr,
  input  logic [WORD_W-1:0]                     proc_wdata,
  output logic                                  proc_stall,
  output logic [WORD_W-1:0]                     proc_rdata,
  output logic                                  read,
  output logic                                  write,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]  addr,
  output logic [WORD_W*LINE_WORDS-1:0]          wdata,
  input  logic [WORD_W*LINE_WORDS-1:0]          rdata,
  input  logic                                  ready,
  input  logic                                  stall,
  output logic [15:0]                           acc_cnt,
  output logic [15:0]                           miss_cnt
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W  = WORD_W * LINE_WORDS;
  localparam int LADDR_W = ADDR_W - OFF_W;

  state_t              state_q, state_d;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAYS-1:0]     dirty_d [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]    tag_d   [SETS][WAYS];
  logic [LINE_W-1:0]   line_q  [SETS][WAYS];
  logic [LINE_W-1:0]   line_d  [SETS][WAYS];
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [WORD_W-1:0]   req_wdata_q, req_wdata_d;
  logic                req_wr_q, req_wr_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic                proc_stall_q, proc_stall_d;
  logic [WORD_W-1:0]   proc_rdata_q, proc_rdata_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [LADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic                acc_inc, miss_inc, lru_hit, hit;
  logic [WAY_W-1:0]    hit_way, vict;
  logic [WAY_W-1:0]    lru_vict [SETS];

  // The request is captured on entry to COMPARE, so the processor only has to present it for one cycle.
  wire [OFF_W-1:0]   req_off  = req_addr_q[OFF_W-1:0];
  wire [IDX_W-1:0]   req_idx  = req_addr_q[OFF_W +: IDX_W];
  wire [TAG_W-1:0]   req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
  wire [LADDR_W-1:0] req_line = req_addr_q[ADDR_W-1:OFF_W];

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    l1_lru #(.WAYS(WAYS), .AGE_W(WAY_W)) u_lru (
      .clk     (clk),
      .rst_n   (proc_reset_n),
      .hit_en  (lru_hit && (req_idx == IDX_W'(s))),
      .hit_way (hit_way),
      .victim  (lru_vict[s])
    );
  end

  // Descending scan leaves the lowest-index invalid way as victim; LRU only when the set is full.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    vict = lru_vict[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) vict = WAY_W'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    line_d       = line_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wr_d     = req_wr_q;
    victim_d     = victim_q;
    proc_stall_d = proc_stall_q;
    proc_rdata_d = proc_rdata_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    acc_inc      = 1'b0;
    miss_inc     = 1'b0;
    lru_hit      = 1'b0;
    if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (proc_read || proc_write) begin
            req_addr_d   = proc_addr;
            req_wdata_d  = proc_wdata;
            req_wr_d     = proc_write && !proc_read;
            proc_stall_d = 1'b1;
            acc_inc      = 1'b1;
            state_d      = COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            lru_hit = 1'b1;
            if (req_wr_q) begin
              line_d[req_idx][hit_way][req_off*WORD_W +: WORD_W] = req_wdata_q;
              dirty_d[req_idx][hit_way] = 1'b1;
            end else begin
              proc_rdata_d = line_q[req_idx][hit_way][req_off*WORD_W +: WORD_W];
            end
            proc_stall_d = 1'b0;
            state_d      = IDLE;
          end else begin
            miss_inc = 1'b1;
            victim_d = vict;
            if (valid_q[req_idx][vict] && dirty_q[req_idx][vict]) begin
              write_d = 1'b1;
              addr_d  = {tag_q[req_idx][vict], req_idx};
              wdata_d = line_q[req_idx][vict];
              state_d = WRITEBACK;
            end else begin
              read_d  = 1'b1;
              addr_d  = req_line;
              state_d = ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (ready) begin
            write_d                    = 1'b0;
            dirty_d[req_idx][victim_q] = 1'b0;
            read_d                     = 1'b1;
            addr_d                     = req_line;
            state_d                    = ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (ready) begin
            read_d                     = 1'b0;
            line_d[req_idx][victim_q]  = rdata;
            tag_d[req_idx][victim_q]   = req_tag;
            valid_d[req_idx][victim_q] = 1'b1;
            dirty_d[req_idx][victim_q] = 1'b0;
            state_d                    = COMPARE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          line_q[s][w] <= '0;
        end
      end
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wr_q     <= 1'b0;
      victim_q     <= '0;
      proc_stall_q <= 1'b0;
      proc_rdata_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wr_q     <= req_wr_d;
      victim_q     <= victim_d;
      proc_stall_q <= proc_stall_d;
      proc_rdata_q <= proc_rdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign proc_stall = proc_stall_q || ((state_q == IDLE) && (proc_read || proc_write));
  assign proc_rdata = proc_rdata_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;

`ifdef L1_PERF_CNT_EN
  logic [15:0] acc_cnt_q, acc_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    acc_cnt_d  = acc_cnt_q + 16'(acc_inc);
    miss_cnt_d = miss_cnt_q + 16'(miss_inc);
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      acc_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign acc_cnt  = acc_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = acc_inc ^ miss_inc;
  assign acc_cnt    = '0;
  assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_l1_cache_nway.sv
// Self-checking bench for l1_cache_nway: processor driver, L2 responder and word-level golden memory.
// Expected L2 requests and processor results are queued when stimulus is issued and popped on DUT output.
module tb_l1_cache_nway;
  import l1_pkg::*;

`ifdef L1_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    bit           wr;
    logic [27:0]  la;
    logic [127:0] line;
  } l2_exp_t;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } pr_exp_t;

  logic clk;
  logic proc_reset_n;
  l1_cache_nway_if bus ();

  l1_cache_nway dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_read    (bus.proc_read),
    .proc_write   (bus.proc_write),
    .proc_addr    (bus.proc_addr),
    .proc_wdata   (bus.proc_wdata),
    .proc_stall   (bus.proc_stall),
    .proc_rdata   (bus.proc_rdata),
    .read         (bus.read),
    .write        (bus.write),
    .addr         (bus.addr),
    .wdata        (bus.wdata),
    .rdata        (bus.rdata),
    .ready        (bus.ready),
    .stall        (bus.stall),
    .acc_cnt      (bus.acc_cnt),
    .miss_cnt     (bus.miss_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int acc_exp = 0;
  int miss_exp = 0;
  int hold_l2 = 0;
  int stall_plan = 0;
  int stall_left = 0;
  logic [29:0] frz;

  l2_exp_t l2_q[$];
  pr_exp_t pr_q[$];
  logic [31:0] l2_words [logic [29:0]];
  logic [31:0] gold [logic [29:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Untouched L2 lines hold a recognisable pattern: 0xAAAA, low byte of (line-4), word index + 1.
  function automatic logic [31:0] l2_word(input logic [29:0] wa);
    logic [7:0] hi;
    logic [7:0] lo;
    if (l2_words.exists(wa)) return l2_words[wa];
    hi = 8'(wa[29:2] - 28'd4);
    lo = 8'(wa[1:0]) + 8'd1;
    return {16'hAAAA, hi, lo};
  endfunction

  function automatic logic [31:0] gold_word(input logic [29:0] wa);
    if (gold.exists(wa)) return gold[wa];
    return l2_word(wa);
  endfunction

  function automatic logic [127:0] gold_line(input logic [27:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = gold_word({la, 2'(i)});
    return l;
  endfunction

  function automatic logic [127:0] l2_line(input logic [27:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = l2_word({la, 2'(i)});
    return l;
  endfunction

  task automatic push_l2(input bit wr, input logic [27:0] la);
    l2_exp_t e;
    e.wr   = wr;
    e.la   = la;
    e.line = wr ? gold_line(la) : '0;
    l2_q.push_back(e);
  endtask

  // L2 model: one request answered per handshake, optionally frozen with stall for stall_plan cycles.
  always @(negedge clk) begin
    l2_exp_t e;
    if (hold_l2 == 0 && proc_reset_n) begin
      if (stall_left > 0) begin
        check_eq("stall_frozen_bus", {bus.read, bus.write, bus.addr}, frz);
        check_eq("stall_frozen_pstall", bus.proc_stall, 1'b1);
        stall_left--;
        if (stall_left == 0) bus.stall = 1'b0;
      end else if (bus.ready) begin
        bus.ready = 1'b0;
      end else if (bus.read || bus.write) begin
        check_eq("l2_rw_exclusive", bus.read & bus.write, 1'b0);
        if (l2_q.size() == 0) begin
          check_eq("l2_unexpected_req", {bus.read, bus.write, bus.addr}, 30'd0);
        end else begin
          e = l2_q.pop_front();
          check_eq("l2_kind", bus.write, e.wr);
          check_eq("l2_addr", bus.addr, e.la);
          if (bus.write) begin
            check_eq("l2_wdata", bus.wdata, e.line);
            for (int i = 0; i < 4; i++) l2_words[{bus.addr, 2'(i)}] = bus.wdata[i*32 +: 32];
          end
        end
        if (bus.read) bus.rdata = l2_line(bus.addr);
        bus.ready = 1'b1;
        if (stall_plan > 0 && bus.read) begin
          bus.stall  = 1'b1;
          stall_left = stall_plan;
          stall_plan = 0;
          frz        = {bus.read, bus.write, bus.addr};
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    proc_reset_n = 1'b0;
    #1;
    check_eq("rst_proc_stall", bus.proc_stall, 1'b0);
    check_eq("rst_proc_rdata", bus.proc_rdata, 32'd0);
    check_eq("rst_read", bus.read, 1'b0);
    check_eq("rst_write", bus.write, 1'b0);
    check_eq("rst_addr", bus.addr, 28'd0);
    check_eq("rst_wdata", bus.wdata, 128'd0);
    check_eq("rst_acc_cnt", bus.acc_cnt, 16'd0);
    check_eq("rst_miss_cnt", bus.miss_cnt, 16'd0);
    @(negedge clk);
    proc_reset_n = 1'b1;
    gold.delete();
    acc_exp  = 0;
    miss_exp = 0;
  endtask

  task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                        input int cyc_exp, input bit miss);
    pr_exp_t e;
    int      cyc;
    bit      done;
    e.rd   = !wr;
    e.data = gold_word(a);
    e.cyc  = cyc_exp;
    pr_q.push_back(e);
    if (wr) gold[a] = wd;
    acc_exp++;
    if (miss) miss_exp++;
    @(negedge clk);
    bus.proc_read  = !wr;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = wd;
    #1;
    check_eq("req_cycle_stall", bus.proc_stall, 1'b1);
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
      #1;
      if (!bus.proc_stall) done = 1'b1;
      else if (cyc >= 60) begin
        check_eq("access_timeout", cyc, cyc_exp);
        done = 1'b1;
      end
    end
    e = pr_q.pop_front();
    check_eq("latency", cyc, e.cyc);
    if (e.rd) check_eq("proc_rdata", bus.proc_rdata, e.data);
    check_eq("acc_cnt", bus.acc_cnt, CNT_EN ? 16'(acc_exp) : 16'd0);
    check_eq("miss_cnt", bus.miss_cnt, CNT_EN ? 16'(miss_exp) : 16'd0);
  endtask

  initial begin
    int cyc;
    proc_reset_n   = 1'b0;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.rdata      = '0;
    bus.ready      = 1'b0;
    bus.stall      = 1'b0;
    do_reset();

    // Cold read miss, then write/read hits on the same line.
    push_l2(1'b0, 28'h4);
    access(1'b0, 30'h10, 32'h0, 4, 1'b1);
    check_eq("first_fill_word", bus.proc_rdata, 32'hAAAA0001);
    access(1'b1, 30'h10, 32'h55, 2, 1'b0);
    access(1'b0, 30'h10, 32'h0, 2, 1'b0);
    access(1'b0, 30'h13, 32'h0, 2, 1'b0);

    // Set 0 replacement: clean LRU eviction, then dirty eviction with writeback.
    do_reset();
    push_l2(1'b0, 28'h0);
    access(1'b1, 30'h00, 32'h55, 4, 1'b1);
    push_l2(1'b0, 28'h10);
    access(1'b0, 30'h40, 32'h0, 4, 1'b1);
    access(1'b0, 30'h00, 32'h0, 2, 1'b0);
    push_l2(1'b0, 28'h20);
    access(1'b0, 30'h80, 32'h0, 4, 1'b1);
    push_l2(1'b1, 28'h0);
    push_l2(1'b0, 28'h10);
    access(1'b0, 30'h40, 32'h0, 6, 1'b1);
    push_l2(1'b0, 28'h0);
    access(1'b0, 30'h00, 32'h0, 4, 1'b1);

    // L2 stall for 5 cycles during the fill, with ready already high.
    stall_plan = 5;
    push_l2(1'b0, 28'h9);
    access(1'b0, 30'h25, 32'h0, 9, 1'b1);

    // Reset in the middle of a writeback abandons it.
    do_reset();
    push_l2(1'b0, 28'h2);
    access(1'b1, 30'h08, 32'h77, 4, 1'b1);
    push_l2(1'b0, 28'h12);
    access(1'b0, 30'h48, 32'h0, 4, 1'b1);
    hold_l2 = 1;
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h88;
    cyc = 0;
    while (!bus.write && cyc < 20) begin
      @(negedge clk);
      bus.proc_read = 1'b0;
      cyc++;
    end
    check_eq("wb_start_cycles", cyc, 2);
    check_eq("wb_addr", bus.addr, 28'h2);
    check_eq("wb_wdata", bus.wdata, gold_line(28'h2));
    proc_reset_n = 1'b0;
    #1;
    check_eq("wb_rst_write", bus.write, 1'b0);
    check_eq("wb_rst_read", bus.read, 1'b0);
    check_eq("wb_rst_pstall", bus.proc_stall, 1'b0);
    @(negedge clk);
    proc_reset_n = 1'b1;
    hold_l2      = 0;
    gold.delete();
    acc_exp  = 0;
    miss_exp = 0;
    push_l2(1'b0, 28'h22);
    access(1'b0, 30'h88, 32'h0, 4, 1'b1);

    repeat (3) @(negedge clk);
    check_eq("l2_queue_drained", l2_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
